// File: rtl/async_fifo_wr_arb_pkg.sv
// Shared definitions for the async FIFO write-port arbiter.
package async_fifo_wr_arb_pkg;

  localparam int unsigned DEF_N_REQ      = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_MAX_BURST  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/async_fifo_wr_arb_pick.sv
// Rotating-priority picker: first set request searching upward from last_grant+1.
module fifo_rr_pick
  import async_fifo_wr_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = DEF_N_REQ,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  winner,
  output logic             any_valid
);

  // Walk the requesters in rotated order and keep the first one found.
  always_comb begin
    int unsigned w_idx;
    w_idx     = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_idx = (32'(last_grant) + k) % N_REQ;
      if (!any_valid && req_valid[w_idx]) begin
        winner    = ID_W'(w_idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ stream sources.
// A grant is held until packet end or MAX_BURST beats.
module async_fifo_wr_arb
  import async_fifo_wr_arb_pkg::*;
#(
  parameter  int unsigned N_REQ      = DEF_N_REQ,
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned MAX_BURST  = DEF_MAX_BURST,
  localparam int unsigned ID_W       = $clog2(N_REQ),
  localparam int unsigned CNT_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                        wr_clk,
  input  logic                        wr_rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  input  logic                        fifo_full,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy
);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [ID_W-1:0]       r_grant_id;
  logic [ID_W-1:0]       r_last_grant;
  logic [CNT_W-1:0]      r_burst_cnt;
  logic [ID_W-1:0]       w_winner;
  logic                  w_any_valid;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_xfer;
  logic                  w_burst_end;

  fifo_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (r_last_grant),
    .winner     (w_winner),
    .any_valid  (w_any_valid)
  );

  // Select the granted requester's valid, last and data.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_grant_id == ID_W'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_xfer      = (r_state == ST_GRANT) & w_sel_valid & ~fifo_full;
  assign w_burst_end = w_xfer & (w_sel_last | (r_burst_cnt == CNT_W'(MAX_BURST - 1)));

  // State register.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state: arbitrate in IDLE, leave GRANT at packet end or burst limit.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any_valid) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_burst_end) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant, last-grant and beat-count registers; the count holds while stalled.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_burst_cnt  <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_any_valid) begin
        r_grant_id  <= w_winner;
        r_burst_cnt <= '0;
      end
    end else if (w_burst_end) begin
      r_last_grant <= r_grant_id;
      r_burst_cnt  <= '0;
    end else if (w_xfer) begin
      r_burst_cnt <= r_burst_cnt + CNT_W'(1);
    end
  end

  // Outputs: ready follows ~full for the granted requester even when it is not valid.
  always_comb begin
    req_ready = '0;
    if (r_state == ST_GRANT && !fifo_full) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (r_grant_id == ID_W'(i)) req_ready[i] = 1'b1;
      end
    end
    fifo_wr_en   = w_xfer;
    fifo_wr_data = w_sel_data;
    grant_id     = r_grant_id;
    busy         = (r_state == ST_GRANT);
  end

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Directed bench for async_fifo_wr_arb: rotation, burst limit, full stall,
// grant lock and asynchronous reset.
module tb_async_fifo_wr_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;

  logic          wr_clk = 1'b0;
  logic          wr_rst_n;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_full;
  logic [1:0]    grant_id;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Source models: requester i sends n_beats beats, data {i, beat}, last every pkt beats.
  int         beat_idx [N] = '{default: 0};
  int         n_beats  [N] = '{default: 0};
  int         pkt      [N] = '{default: 1};
  logic [N-1:0] hold;
  logic       src_clr;
  logic [7:0] log_q [$];
  logic [7:0] want_q [$];
  int         base;

  async_fifo_wr_arb #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .wr_clk       (wr_clk),
    .wr_rst_n     (wr_rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 wr_clk = ~wr_clk;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      req_valid[i]          = !src_clr && !hold[i] && (beat_idx[i] < n_beats[i]);
      req_last[i]           = ((beat_idx[i] + 1) % pkt[i]) == 0;
      req_data[i*DW +: DW]  = {4'(i), 4'(beat_idx[i])};
    end
  end

  always @(posedge wr_clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (src_clr) beat_idx[i] <= 0;
      else if (req_valid[i] && req_ready[i]) beat_idx[i] <= beat_idx[i] + 1;
    end
  end

  always @(posedge wr_clk) begin
    if (wr_rst_n && fifo_wr_en) log_q.push_back(fifo_wr_data);
  end

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, 32'(log_q.size() - base), 32'(want_q.size()));
    for (int k = 0; k < want_q.size(); k++) begin
      if (base + k < log_q.size())
        chk($sformatf("%s_%0d", tag, k), 32'(log_q[base + k]), 32'(want_q[k]));
    end
  endtask

  task automatic set_src(input int i, input int n, input int p);
    n_beats[i] = n;
    pkt[i]     = p;
  endtask

  task automatic new_test();
    src_clr = 1'b1;
    for (int i = 0; i < int'(N); i++) set_src(i, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, then all requesters valid with single-beat packets.
    wr_rst_n  = 1'b0;
    fifo_full = 1'b0;
    hold      = '0;
    src_clr   = 1'b1;
    for (int i = 0; i < int'(N); i++) set_src(i, 255, 1);
    #2;
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    tick();
    src_clr = 1'b0;
    #1;
    chk("rst_wr_en_valid", fifo_wr_en, 0);
    chk("rst_ready_valid", req_ready, 0);
    tick();
    wr_rst_n = 1'b1;
    base = log_q.size();
    for (int g = 0; g < 5; g++) begin
      tick(); #1;
      chk($sformatf("t1_grant%0d", g), grant_id, g % 4);
      chk($sformatf("t1_wren%0d", g), fifo_wr_en, 1);
      chk($sformatf("t1_ready%0d", g), req_ready, 1 << (g % 4));
      chk($sformatf("t1_data%0d", g), fifo_wr_data, {4'(g % 4), 4'(g / 4)});
      tick(); #1;
      chk($sformatf("t1_idle_busy%0d", g), busy, 0);
      chk($sformatf("t1_idle_wren%0d", g), fifo_wr_en, 0);
    end
    want_q = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01};
    chk_log("t1_log");

    // Burst limit: req1 10-beat packet interleaved with req2 2-beat packet.
    new_test();
    set_src(1, 10, 10);
    set_src(2, 2, 2);
    base = log_q.size();
    tick();
    src_clr = 1'b0;
    repeat (20) tick();
    #1;
    chk("t2_busy_end", busy, 0);
    want_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21,
               8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    chk_log("t2_log");

    // Full stall for 3 cycles after two beats of req0.
    new_test();
    set_src(0, 6, 6);
    base = log_q.size();
    tick();
    src_clr = 1'b0;
    tick(); #1;
    chk("t3_grant", grant_id, 0);
    chk("t3_busy", busy, 1);
    chk("t3_wren", fifo_wr_en, 1);
    tick();
    tick();
    fifo_full = 1'b1;
    #1;
    chk("t3_full_wren0", fifo_wr_en, 0);
    chk("t3_full_ready0", req_ready, 0);
    tick(); #1;
    chk("t3_full_wren1", fifo_wr_en, 0);
    chk("t3_full_busy1", busy, 1);
    tick(); #1;
    chk("t3_full_wren2", fifo_wr_en, 0);
    tick();
    fifo_full = 1'b0;
    #1;
    chk("t3_resume_wren", fifo_wr_en, 1);
    chk("t3_resume_data", fifo_wr_data, 8'h02);
    tick();
    tick(); #1;
    chk("t3_burst_end_busy", busy, 0);
    tick();
    tick();
    tick(); #1;
    chk("t3_done_busy", busy, 0);
    want_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk_log("t3_log");

    // Grant lock: req3 drops valid for 2 cycles while req0 waits.
    new_test();
    set_src(3, 3, 3);
    set_src(0, 1, 1);
    base = log_q.size();
    tick();
    src_clr = 1'b0;
    tick(); #1;
    chk("t4_grant3", grant_id, 3);
    chk("t4_busy", busy, 1);
    tick();
    hold = 4'b1000;
    #1;
    chk("t4_hold_wren0", fifo_wr_en, 0);
    chk("t4_hold_grant0", grant_id, 3);
    chk("t4_hold_ready0", req_ready, 4'b1000);
    tick(); #1;
    chk("t4_hold_wren1", fifo_wr_en, 0);
    chk("t4_hold_grant1", grant_id, 3);
    chk("t4_hold_busy1", busy, 1);
    tick();
    hold = '0;
    #1;
    chk("t4_rel_wren", fifo_wr_en, 1);
    chk("t4_rel_data", fifo_wr_data, 8'h31);
    tick();
    tick(); #1;
    chk("t4_end_busy", busy, 0);
    tick(); #1;
    chk("t4_next_grant", grant_id, 0);
    tick(); #1;
    want_q = '{8'h30, 8'h31, 8'h32, 8'h00};
    chk_log("t4_log");

    // Asynchronous reset mid-burst of req2.
    new_test();
    set_src(2, 8, 8);
    set_src(0, 1, 1);
    tick();
    src_clr = 1'b0;
    tick(); #1;
    chk("t5_grant2", grant_id, 2);
    tick(); #1;
    chk("t5_wren_pre", fifo_wr_en, 1);
    wr_rst_n = 1'b0;
    #1;
    chk("t5_async_wren", fifo_wr_en, 0);
    chk("t5_async_ready", req_ready, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_grant", grant_id, 0);
    src_clr = 1'b1;
    tick();
    tick();
    src_clr  = 1'b0;
    wr_rst_n = 1'b1;
    tick(); #1;
    chk("t5_first_grant", grant_id, 0);
    chk("t5_first_busy", busy, 1);
    chk("t5_first_ready", req_ready, 4'b0001);
    chk("t5_first_data", fifo_wr_data, 8'h00);
    tick(); #1;
    chk("t5_after_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
